// File: rtl/muldiv_if.sv
// Handshake and data bundle between the control unit and the multiply/divide unit.
// The master side issues operations and MTHI/MTLO writes; the slave side owns HI/LO.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic             wr_hi;
   logic             wr_lo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srcA, srcB, wr_hi, wr_lo,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, srcA, srcB, wr_hi, wr_lo,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the result signs are applied in FIN.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input logic     clk,
   input logic     reset,
   muldiv_if.slave bus
);
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   state_t             state, state_n;
   op_t                op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               qneg_q;
   logic               rneg_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   logic               last;
   logic               is_div;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;

   assign last   = (cnt == CW'(ITER-1));
   assign is_div = op_q[1];

   // Operand magnitudes; op[0] marks the signed variants.
   always_comb begin
      a_neg = bus.op[0] & bus.srcA[WIDTH-1];
      b_neg = bus.op[0] & bus.srcB[WIDTH-1];
      mag_a = a_neg ? (~bus.srcA + 1'b1) : bus.srcA;
      mag_b = b_neg ? (~bus.srcB + 1'b1) : bus.srcB;
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = RUN;
         RUN:     if (last)      state_n = FIN;
         FIN:                    state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Iteration step
   // ---------------------------------------------------------------
   // Multiply: low half holds the remaining multiplier bits, high half the
   // running partial product; add with carry, then shift right one place.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;

   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, b_q} & {(WIDTH+1){acc[0]}});
      mul_nxt = {mul_sum, acc[WIDTH-1:1]};
   end

   // Divide: shift remainder:quotient left, trial-subtract the divisor and
   // keep the difference only when it did not go negative.
   logic [WIDTH:0]     div_rsh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] div_nxt;

   always_comb begin
      div_rsh  = acc[2*WIDTH-1:WIDTH-1];
      div_diff = {1'b0, div_rsh} - {2'b00, b_q};
      if (div_diff[WIDTH+1])
         div_nxt = {div_rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // ---------------------------------------------------------------
   // Final sign correction
   // ---------------------------------------------------------------
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               div0;

   always_comb begin
      prod = qneg_q ? (~acc + 1'b1) : acc;
      quo  = qneg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      rem  = rneg_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      div0 = (b_q == '0);
      if (!is_div) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (div0) begin
         // Divide by zero reports all-ones quotient and the raw dividend.
         res_hi = a_q;
         res_lo = '1;
      end else begin
         res_hi = rem;
         res_lo = quo;
      end
   end

   // ---------------------------------------------------------------
   // Datapath and HI/LO
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= OP_MULTU;
         a_q    <= '0;
         b_q    <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= op_t'(bus.op);
                  a_q    <= bus.srcA;
                  b_q    <= mag_b;
                  qneg_q <= a_neg ^ b_neg;
                  rneg_q <= a_neg;
                  acc    <= {{WIDTH{1'b0}}, mag_a};
                  cnt    <= '0;
               end else begin
                  if (bus.wr_hi) hi_q <= bus.srcA;
                  if (bus.wr_lo) lo_q <= bus.srcA;
               end
            end
            RUN: begin
               acc <= is_div ? div_nxt : mul_nxt;
               cnt <= cnt + CW'(1);
            end
            FIN: begin
               hi_q   <= res_hi;
               lo_q   <= res_lo;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS32 datapath.
- Covers the MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions, which the single-cycle ALU does not execute, and owns the architectural HI/LO registers.
- The control unit issues an operation with a start pulse and stalls the pipeline while busy is high. MFHI/MFLO read the hi/lo ports directly.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srcA  input  32  multiplicand / dividend; also MTHI/MTLO data.
- srcB  input  32  multiplier / divisor.
- wr_hi  input  1  MTHI: hi <= srcA.
- wr_lo  input  1  MTLO: lo <= srcA.
- busy  output  1  operation in progress; the pipeline must stall.
- done  output  1  one-cycle pulse when the result is written.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is asserted: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal registers cleared.
- Reset mid-operation aborts the operation. No done pulse is produced and no HI/LO write occurs.
- States:
  - IDLE: accept start/wr_hi/wr_lo.
  - RUN: one iteration per clock.
  - FIN: sign correction and HI/LO write.
- IDLE transitions:
  - start=1 at edge E0 latches op, srcA and srcB. For signed ops it also latches the operand magnitudes and result signs. Counter <= 0, state -> RUN, busy=1 from E0.
  - start=0: wr_hi writes hi <= srcA and wr_lo writes lo <= srcA at that edge. Both may be asserted together.
  - If start=1 in the same cycle, start has priority and the wr_hi/wr_lo writes are dropped.
- RUN:
  - Multiply: radix-2 shift-add on a 64-bit product register.
  - Divide: restoring shift-subtract on a 64-bit remainder:quotient register.
  - Counter increments at each edge E1..E32. At E32 (counter=31) state -> FIN.
- FIN to IDLE at edge E33:
  - Writes hi/lo. done=1 for exactly the cycle following E33. busy=0 from E33.
  - Total latency: results are visible 33 clocks after the start edge.
- Ignored inputs: start, wr_hi and wr_lo asserted while busy (RUN/FIN) are ignored, with no queuing. srcA/srcB changes after E0 have no effect.
- A new start may be accepted in the cycle done is high. That edge is E0 of the next operation.
- Multiply results:
  - {hi,lo} = 64-bit product.
  - MULTU: unsigned × unsigned.
  - MULT: two's-complement. Multiply the magnitudes, then negate the 64-bit product in FIN if the operand signs differ.
- Divide results:
  - lo = quotient, truncated toward zero. hi = remainder; its sign follows the dividend; |hi| < |srcB|.
  - DIV computes on magnitudes. In FIN, negate the quotient if the signs differ, and negate the remainder if the dividend was negative.
- Divide boundary cases:
  - Divide by zero (srcB=0, DIV or DIVU): lo=32'hFFFF_FFFF, hi=srcA as latched. Still takes the full 33 cycles. No exception is raised.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. This is 32-bit wrap, with no trap.
  - The magnitude of 32'h8000_0000 is handled as unsigned 32'h8000_0000.

Test Plan:
- MULTU srcA=32'hFFFF_FFFF, srcB=32'hFFFF_FFFF -> done pulses 33 cycles after start; hi=32'hFFFF_FFFE, lo=32'h0000_0001; busy high for cycles 1..33.
- MULT srcA=-3, srcB=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Also MULT 32'h8000_0000 × 32'h8000_0000 -> hi=32'h4000_0000, lo=0.
- DIV srcA=-7, srcB=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU srcA=100, srcB=7 -> lo=14, hi=2.
- Divide edge cases: DIVU srcA=32'h1234_5678, srcB=0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678. DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- MTHI/MTLO interaction:
  - wr_hi=1, wr_lo=1 with srcA=32'hDEAD_BEEF while idle -> hi=lo=32'hDEAD_BEEF next cycle.
  - wr_lo asserted mid-RUN -> ignored; lo equals the operation's result.
  - wr_hi with start in the same cycle -> write dropped.
- Reset and restart:
  - Assert reset asynchronously (off clock edge) at RUN counter=15 -> busy, done, hi and lo go to 0 immediately; no done pulse follows.
  - A start pulse during busy is ignored.
  - Back-to-back start in the done cycle yields a second result 33 cycles later.
